// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state codes, scancode prefixes, queue entry layout.
// Entry = {extended, released, code[7:0]}.
package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    localparam int PS2_CODE_W  = 8;
    localparam int PS2_ENTRY_W = 10;
    localparam int PS2_REL_BIT = 8;
    localparam int PS2_EXT_BIT = 9;

    typedef logic [PS2_ENTRY_W-1:0] ps2_entry_t;

    function automatic ps2_entry_t ps2_mk_entry(input logic ext, input logic rel,
                                                input logic [PS2_CODE_W-1:0] code);
        ps2_entry_t e;
        e = '0;
        e[PS2_EXT_BIT]        = ext;
        e[PS2_REL_BIT]        = rel;
        e[PS2_CODE_W-1:0]     = code;
        return e;
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy level and simultaneous push/pop.
// Latency: write visible at o_rd_dat the clk after i_wr_en; full drops writes unless a pop coincides.
// Backpressure: o_full reported to the writer; reads while empty are ignored.
module ps2_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_dat,
    input  logic                     i_rd_en,
    output logic                     o_rd_vld,
    output logic [WIDTH-1:0]         o_rd_dat,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_empty;
    logic             w_do_rd;
    logic             w_do_wr;

    assign w_empty  = (r_level == '0);
    assign o_full   = (r_level == LW'(DEPTH));
    assign w_do_rd  = i_rd_en & ~w_empty;
    assign w_do_wr  = i_wr_en & (~o_full | w_do_rd);
    assign o_rd_vld = ~w_empty;
    assign o_rd_dat = r_mem[r_rptr];
    assign o_level  = r_level;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wptr] <= i_wr_dat;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_rd) r_rptr <= r_rptr + 1'b1;
            if (w_do_wr && !w_do_rd)      r_level <= r_level + 1'b1;
            else if (!w_do_wr && w_do_rd) r_level <= r_level - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 frame receiver with prefix folding and FWFT scancode queue (optional error counters: PS2_RX_STATS_EN).
// Latency: entry pushed the clk after the stop-bit edge, visible at rd_* one clk later.
// Backpressure: none toward the device; a full queue drops the code and sets sticky overflow.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN   = 16,
    parameter int TIMEOUT_BITS = 24,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_rcv,
    input  logic                          kb_or_mouse,
    input  logic                          ps2clk_ext,
    input  logic                          ps2data_ext,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [PS2_ENTRY_W-1:0]        rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow,
`ifdef PS2_RX_STATS_EN
    input  logic                          clr_stats,
    output logic [7:0]                    parity_cnt,
    output logic [7:0]                    stop_cnt,
    output logic [7:0]                    timeout_cnt,
`endif
    output logic                          frame_err
);
    localparam int HALF = FILTER_LEN / 2;
    localparam logic [FILTER_LEN-1:0] FALL_PAT = {{HALF{1'b1}}, {HALF{1'b0}}};

    logic                    r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FILTER_LEN-1:0]   r_filt;
    logic [1:0]              r_state;
    logic [7:0]              r_shift;
    logic [TIMEOUT_BITS-1:0] r_tmo;
    logic                    r_ext, r_rel;
    logic                    r_push_vld;
    ps2_entry_t              r_push_dat;
    logic                    r_ferr, r_ovf;
    logic                    w_edge, w_adv, w_tmo_hit;
    logic                    w_par_err, w_stop_err, w_accept;
    logic                    w_full, w_pop, w_drop;

    // Filter holds newest sample at bit 0: a settled high run followed by a settled low run is a fall.
    assign w_edge     = (r_filt == FALL_PAT);
    assign w_adv      = w_edge & enable_rcv;
    assign w_tmo_hit  = (r_state != ST_IDLE) && !w_adv && (&r_tmo);
    assign w_par_err  = w_adv && (r_state == ST_PARITY) && !(^r_shift ^ r_dat_s2);
    assign w_stop_err = w_adv && (r_state == ST_STOP) && !r_dat_s2;
    assign w_accept   = w_adv && (r_state == ST_STOP) && r_dat_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_dat_s1 <= 1'b0;
            r_dat_s2 <= 1'b0;
            r_filt   <= '0;
        end else begin
            r_clk_s1 <= ps2clk_ext;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2data_ext;
            r_dat_s2 <= r_dat_s1;
            r_filt   <= {r_filt[FILTER_LEN-2:0], r_clk_s2};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_tmo   <= '0;
        end else begin
            if (r_state == ST_IDLE || w_adv || w_tmo_hit) r_tmo <= '0;
            else                                          r_tmo <= r_tmo + 1'b1;

            if (w_tmo_hit) begin
                r_state <= ST_IDLE;
            end else if (w_adv) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state <= ST_DATA;
                            r_shift <= 8'h80;
                        end
                    end
                    ST_DATA: begin
                        // Sentinel at bit 0 means this edge carries the 8th data bit.
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                        if (r_shift[0]) r_state <= ST_PARITY;
                    end
                    ST_PARITY: r_state <= (^r_shift ^ r_dat_s2) ? ST_STOP : ST_IDLE;
                    ST_STOP:   r_state <= ST_IDLE;
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ext      <= 1'b0;
            r_rel      <= 1'b0;
            r_push_vld <= 1'b0;
            r_push_dat <= '0;
            r_ferr     <= 1'b0;
        end else begin
            r_push_vld <= 1'b0;
            r_ferr     <= w_par_err | w_stop_err | w_tmo_hit;
            if (w_accept) begin
                if (!kb_or_mouse && r_shift == PS2_PREFIX_EXT) begin
                    r_ext <= 1'b1;
                end else if (!kb_or_mouse && r_shift == PS2_PREFIX_REL) begin
                    r_rel <= 1'b1;
                end else begin
                    r_push_vld <= 1'b1;
                    r_push_dat <= ps2_mk_entry(r_ext & ~kb_or_mouse, r_rel & ~kb_or_mouse, r_shift);
                    r_ext      <= 1'b0;
                    r_rel      <= 1'b0;
                end
            end
            if (kb_or_mouse || w_tmo_hit) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end
        end
    end

    assign w_pop  = rd_en & rd_valid;
    assign w_drop = r_push_vld & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n)            r_ovf <= 1'b0;
        else if (w_drop)       r_ovf <= 1'b1;
        else if (clr_overflow) r_ovf <= 1'b0;
    end

    assign overflow  = r_ovf;
    assign frame_err = r_ferr;

    ps2_sync_fifo #(
        .WIDTH (PS2_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_wr_en  (r_push_vld),
        .i_wr_dat (r_push_dat),
        .i_rd_en  (rd_en),
        .o_rd_vld (rd_valid),
        .o_rd_dat (rd_data),
        .o_level  (fifo_level),
        .o_full   (w_full)
    );

`ifdef PS2_RX_STATS_EN
    logic [7:0] r_par_cnt, r_stop_cnt, r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            r_par_cnt  <= '0;
            r_stop_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            if (w_par_err  && r_par_cnt  != 8'hFF) r_par_cnt  <= r_par_cnt  + 8'd1;
            if (w_stop_err && r_stop_cnt != 8'hFF) r_stop_cnt <= r_stop_cnt + 8'd1;
            if (w_tmo_hit  && r_tmo_cnt  != 8'hFF) r_tmo_cnt  <= r_tmo_cnt  + 8'd1;
        end
    end

    assign parity_cnt  = r_par_cnt;
    assign stop_cnt    = r_stop_cnt;
    assign timeout_cnt = r_tmo_cnt;
`endif

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 receiver (keyboard or mouse) with a buffered scancode queue. Captures 11-bit device-to-host frames, checks odd parity and stop bit, and folds the E0/F0 prefixes into per-entry flags in keyboard mode. Decoded codes go into a first-word-fall-through (FWFT) FIFO, so the host side can drain bursts without losing keys. Replaces single-register, single-pulse PS/2 reception in the input subsystem.

Parameters:
FILTER_LEN, 16, deglitch shift length (even, >=4); falling edge = upper FILTER_LEN/2 samples 1, lower FILTER_LEN/2 samples 0
TIMEOUT_BITS, 24, width of mid-frame timeout counter; abort after 2^TIMEOUT_BITS-1 clk without a falling edge
FIFO_DEPTH, 8, queue entries, power of 2, >=2

Ports:
clk  in  1  system clock, 1-600 MHz
rst_n  in  1  synchronous active-low reset
enable_rcv  in  1  1 = frame state machine advances on edges; 0 = edges ignored
kb_or_mouse  in  1  0 = keyboard (prefix decode), 1 = mouse (raw bytes)
ps2clk_ext  in  1  PS/2 clock line, asynchronous
ps2data_ext  in  1  PS/2 data line, asynchronous
rd_en  in  1  pop head entry when rd_valid=1
rd_valid  out  1  FIFO not empty
rd_data  out  10  {extended, released, code[7:0]} at FIFO head
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky; a code was dropped because the FIFO was full
clr_overflow  in  1  clears overflow
frame_err  out  1  1-clk pulse on parity error, stop-bit error or timeout abort

Behaviour:
- Input sync: 2-flop synchroniser on each line, then FILTER_LEN shift register on the synced clock. Edge = one-clk strobe when the pattern matches.
- Reset (rst_n=0 at a clk edge): state IDLE; filter and synchronisers = 0 (idle-high line refills with no false edge); FIFO empty; rd_valid=0, rd_data=0, fifo_level=0, overflow=0, frame_err=0; prefix flags=0; timeout=0. Reset mid-frame discards the partial frame.
- FSM, advanced only on edge && enable_rcv:
  - IDLE: data=0 -> DATA, shift register preset 8'h80 (sentinel). Data=1 -> stays in IDLE.
  - DATA: shift data in at bit 7, LSB first. Sentinel reaching bit 0 -> PARITY after the 8th bit.
  - PARITY: ^key ^ data must equal 1. Pass -> STOP. Fail -> IDLE with frame_err pulse.
  - STOP: data=1 -> accept byte. Data=0 -> frame_err pulse, no accept. Always -> IDLE.
- Timeout: counts clk while state != IDLE and no qualifying edge; clears on each edge. At all-ones -> IDLE, frame_err pulse, prefix flags cleared. Held at 0 in IDLE.
- Accept, keyboard: E0 sets ext_pend; F0 sets rel_pend; no push for either. Any other byte pushes {ext_pend, rel_pend, byte}, then clears both flags.
- Accept, mouse: push {2'b00, byte}. Prefix flags forced to 0.
- Push happens in the clk after the stop-bit edge. rd_valid/rd_data/fifo_level update the following clk (FWFT).
- Full, push only: entry dropped, overflow set, prefix flags still cleared.
- Full, push and pop together: both happen; level unchanged; no overflow.
- Empty and rd_en: ignored.
- Pointers wrap modulo FIFO_DEPTH. The level counter disambiguates full from empty.
- clr_overflow and a new overflow in the same clk: overflow ends up set.

Optional Feature:
PS2_RX_STATS_EN
- Defined: adds outputs parity_cnt, stop_cnt, timeout_cnt, each 8 bits.
  - Each is a saturating counter (sticks at 255), incremented on its error cause.
  - All are cleared by reset or by a new input clr_stats.
- Undefined: no ports, no counters, no logic.

Decomposition:
- Package ps2_pkg: FSM state enum (IDLE/DATA/PARITY/STOP); PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_REL=8'hF0; entry width constant 10 and entry field positions.
- Sub-module ps2_sync_fifo: parametrised width/depth FWFT FIFO with level and simultaneous push/pop. Reusable by the mouse and joystick paths.

Test Plan:
- Keyboard, frame 0x1C with parity 0, stop 1 -> rd_valid=1, rd_data=10'h01C, fifo_level=1; rd_en pulse -> rd_valid=0.
- Keyboard, E0,F0,75 -> exactly one entry, rd_data=10'h375; a following 0x1C -> 10'h01C (flags cleared).
- Mouse, 0xF0 then 0x08 -> two entries, 10'h0F0 and 10'h008.
- 0x1C with parity 1 -> frame_err one pulse, no push. Then 0x1C with stop 0 -> frame_err, no push.
- TIMEOUT_BITS=10: start + 4 bits, clock held high 1100 clk -> frame_err, FSM back in IDLE; next valid 0x29 received as 10'h029.
- FIFO_DEPTH=8: 9 codes, no reads -> level 8, overflow=1, entries 1-8 intact; clr_overflow -> 0. Also: rst_n low mid-frame -> empty FIFO and clean reception of the next frame.
